// File: rtl/ball_controller.sv
// ball_controller: serves, moves and bounces the ball and detects goals; optional BALL_SPEEDUP_EN adds a per-hit step increase
module ball_controller #(
  parameter logic [11:0] X_LEFT     = 12'd140,
  parameter logic [11:0] X_RIGHT    = 12'd500,
  parameter logic [11:0] Y_MIN      = 12'd175,
  parameter logic [11:0] Y_MAX      = 12'd426,
  parameter logic [11:0] PADDLE_LEN = 12'd28,
  parameter logic [11:0] PADDLE_W   = 12'd4,
  parameter logic [11:0] BALL_SIZE  = 12'd4,
  parameter logic [11:0] BALL_X0    = 12'd320,
  parameter logic [11:0] BALL_Y0    = 12'd300,
  parameter logic [7:0]  SERVE_DLY  = 8'd60
) (
  input  logic        clkP,
  input  logic        Reset,
  input  logic [23:0] PPosition,
  input  logic [23:0] CPosition,
  output logic [23:0] BPosition,
  output logic        PScore,
  output logic        CScore,
  output logic        Serving
);
  typedef enum logic [1:0] {SERVE, MOVE, SCORED} state_t;
  state_t state, state_n;
  logic [7:0] counter, counter_n;
  logic dx, dy, dx_n, dy_n, dx_m, dy_m;
  logic [23:0] pos_n;
  logic ps_n, cs_n, p_hit, c_hit, p_goal, c_goal, top, bot;
  logic [11:0] bx, by, px, py, cx, cy, nx, ny, st;
  logic [12:0] ny_w;
`ifdef BALL_SPEEDUP_EN
  logic [1:0] step, step_n;
`else
  localparam logic [1:0] step = 2'd1;
`endif
  localparam logic [23:0] SERVE_POS = {BALL_Y0, BALL_X0};
  function automatic logic [12:0] ext(input logic [11:0] v);
    return {1'b0, v};
  endfunction
  assign bx = BPosition[11:0];
  assign by = BPosition[23:12];
  assign px = PPosition[11:0];
  assign py = PPosition[23:12];
  assign cx = CPosition[11:0];
  assign cy = CPosition[23:12];
  assign st = {10'd0, step};
  // bounce, goal and next-position decisions for the current tick (dx/dy: 1 = +1, 0 = -1)
  always_comb begin
    p_hit = !dx && ext(bx) <= ext(px) + ext(PADDLE_W) && bx >= px &&
            ext(by) + ext(BALL_SIZE) > ext(py) && ext(by) < ext(py) + ext(PADDLE_LEN);
    c_hit = dx && ext(bx) + ext(BALL_SIZE) >= ext(cx) && bx <= cx &&
            ext(by) + ext(BALL_SIZE) > ext(cy) && ext(by) < ext(cy) + ext(PADDLE_LEN);
    top = !dy && by <= Y_MIN;
    bot = dy && ext(by) + ext(BALL_SIZE) >= ext(Y_MAX);
    c_goal = !dx && bx <= X_LEFT && !p_hit;
    p_goal = dx && ext(bx) + ext(BALL_SIZE) >= ext(X_RIGHT) && !c_hit;
    dx_m = p_hit ? 1'b1 : c_hit ? 1'b0 : dx;
    dy_m = top ? 1'b1 : bot ? 1'b0 : dy;
    nx = dx_m ? bx + st : bx - st;
    ny_w = dy_m ? ext(by) + ext(st) : ext(by) - ext(st);
    ny = ny_w < ext(Y_MIN) ? Y_MIN :
         ny_w > ext(Y_MAX) - ext(BALL_SIZE) ? Y_MAX - BALL_SIZE : ny_w[11:0];
  end
  // next-state and registered-output logic of the serve/move/scored FSM
  always_comb begin
    state_n = state;
    counter_n = counter;
    dx_n = dx;
    dy_n = dy;
    pos_n = BPosition;
    ps_n = 1'b0;
    cs_n = 1'b0;
`ifdef BALL_SPEEDUP_EN
    step_n = step;
`endif
    case (state)
      SERVE: begin
        pos_n = SERVE_POS;
        counter_n = counter == SERVE_DLY - 8'd1 ? 8'd0 : counter + 8'd1;
        state_n = counter == SERVE_DLY - 8'd1 ? MOVE : SERVE;
      end
      MOVE: begin
        if (c_goal || p_goal) begin
          state_n = SCORED;
          cs_n = c_goal;
          ps_n = p_goal;
          pos_n = SERVE_POS;
        end else begin
          dx_n = dx_m;
          dy_n = dy_m;
          pos_n = {ny, nx};
`ifdef BALL_SPEEDUP_EN
          step_n = (p_hit || c_hit) && step != 2'd3 ? step + 2'd1 : step;
`endif
        end
      end
      SCORED: begin
        state_n = SERVE;
        counter_n = 8'd0;
        dx_n = CScore;
        dy_n = !dy;
        pos_n = SERVE_POS;
`ifdef BALL_SPEEDUP_EN
        step_n = 2'd1;
`endif
      end
      default: state_n = SERVE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clkP) begin
    if (Reset) begin
      state <= SERVE;
      counter <= 8'd0;
      dx <= 1'b0;
      dy <= 1'b1;
      BPosition <= SERVE_POS;
      PScore <= 1'b0;
      CScore <= 1'b0;
      Serving <= 1'b1;
`ifdef BALL_SPEEDUP_EN
      step <= 2'd1;
`endif
    end else begin
      state <= state_n;
      counter <= counter_n;
      dx <= dx_n;
      dy <= dy_n;
      BPosition <= pos_n;
      PScore <= ps_n;
      CScore <= cs_n;
      Serving <= state_n == SERVE;
`ifdef BALL_SPEEDUP_EN
      step <= step_n;
`endif
    end
  end
endmodule
